// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared state type and constants for the memory responder
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int OFF_W      = $clog2(WORD_BYTES);
    localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_resp_array.sv
// rtl/mem_resp_array.sv - DEPTH x n word storage, synchronous write, combinational read
module mem_resp_array #(
    parameter int n     = 32,
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [n-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [n-1:0]  rdata_o
);

    // Contents deliberately survive reset.
    logic [n-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding load/store responder with fixed wait states
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int n           = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         req_valid,
    input  logic         req_we,
    input  logic [n-1:0] req_addr,
    input  logic [n-1:0] req_wdata,
    output logic         req_ready,
    output logic         resp_valid,
    output logic [n-1:0] resp_rdata,
    output logic         resp_err,
    input  logic         resp_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [n-1:0]     addr_q;
    logic [n-1:0]     wdata_q;
    logic [n-1:0]     rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             accept;
    logic             enter_resp;
    logic             cur_we;
    logic [n-1:0]     cur_addr;
    logic [n-1:0]     cur_wdata;
    logic             cur_err;
    logic [AW-1:0]    cur_idx;
    logic             arr_we;
    logic [n-1:0]     arr_rdata;

    assign req_ready  = (state_q == IDLE) && rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With zero wait states RESP is entered on the accept edge itself,
    // so the live request fields are used before they are latched.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

    assign cur_err = (cur_addr[OFF_W-1:0] != '0) ||
                     ((cur_addr >> (AW + OFF_W)) != '0);
    assign cur_idx = cur_addr[AW+OFF_W-1:OFF_W];
    assign arr_we  = enter_resp && cur_we && !cur_err && rst;

    mem_resp_array #(
        .n     (n),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (arr_we),
        .waddr_i (cur_idx),
        .wdata_i (cur_wdata),
        .raddr_i (cur_idx),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (enter_resp) begin
            err_d   = cur_err;
            rdata_d = (cur_we || cur_err) ? '0 : arr_rdata;
        end
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    localparam int N = 32;

    logic         CLK = 1'b0;
    logic         rst = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    logic [N-1:0] req_addr = '0;
    logic [N-1:0] req_wdata = '0;
    logic         resp_ready = 1'b1;
    logic         req_ready;
    logic         resp_valid;
    logic [N-1:0] resp_rdata;
    logic         resp_err;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    mem_responder #(
        .n           (N),
        .DEPTH       (256),
        .WAIT_CYCLES (2)
    ) dut (
        .CLK        (CLK),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .resp_ready (resp_ready)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issues one request and returns at the first sample point showing resp_valid.
    // lat counts edges after the accept edge; -1 means no response appeared.
    task automatic do_txn(input logic we, input logic [N-1:0] addr, input logic [N-1:0] wdata,
                          output logic [N-1:0] rdata, output logic err, output int lat);
        int guard;
        guard = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (resp_valid) begin
                lat   = i;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL rst_resp_err got %b want 0", resp_err); end
        rst = 1'b1;
        #1;
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got %b want 1", req_ready); end
        tick();
    endtask

    task automatic test_store_load();
        logic [N-1:0] rd;
        logic er;
        int lat;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        tick();
        // Scramble the request lines after accept; the latched copy must be used.
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h13; req_wdata = 32'h0;
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL st_ready_e0 got %b want 0", req_ready); end
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL st_valid_e0 got %b want 0", resp_valid); end
        tick();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL st_valid_e1 got %b want 0", resp_valid); end
        tick();
        // Third edge counting the accept edge.
        vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL st_valid_e2 got %b want 1", resp_valid); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL st_err got %b want 0", resp_err); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL st_rdata got %h want 0", resp_rdata); end
        tick();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL st_valid_fall got %b want 0", resp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL st_ready_back got %b want 1", req_ready); end
        do_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL ld_latency got %0d want 2", lat); end
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ld_rdata got %h want deadbeef", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ld_err got %b want 0", er); end
        tick();
    endtask

    task automatic test_misaligned();
        logic [N-1:0] rd;
        logic er;
        int lat;
        do_txn(1'b0, 32'h13, 32'h0, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL mis_ld_err got %b want 1", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL mis_ld_rdata got %h want 0", rd); end
        tick();
        do_txn(1'b1, 32'h12, 32'h11111111, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL mis_st_err got %b want 1", er); end
        tick();
        do_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mis_after_rdata got %h want deadbeef", rd); end
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL mis_after_err got %b want 0", er); end
        tick();
    endtask

    task automatic test_out_of_range();
        logic [N-1:0] rd;
        logic er;
        int lat;
        do_txn(1'b1, 32'h000, 32'hA5A50001, rd, er, lat);
        tick();
        do_txn(1'b1, 32'h400, 32'hFFFFFFFF, rd, er, lat);
        vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL oor_st_err got %b want 1", er); end
        vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL oor_st_rdata got %h want 0", rd); end
        tick();
        do_txn(1'b0, 32'h000, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hA5A50001) begin miscompares++; $display("FAIL oor_word0 got %h want a5a50001", rd); end
        tick();
        do_txn(1'b1, 32'h3FC, 32'h0BADF00D, rd, er, lat);
        vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL last_st_err got %b want 0", er); end
        tick();
        do_txn(1'b0, 32'h3FC, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h0BADF00D) begin miscompares++; $display("FAIL last_ld_rdata got %h want 0badf00d", rd); end
        tick();
    endtask

    task automatic test_hold();
        logic [N-1:0] rd;
        logic er;
        int lat;
        resp_ready = 1'b0;
        do_txn(1'b0, 32'h10, 32'h0, rd, er, lat);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL hold_latency got %0d want 2", lat); end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++; if (resp_valid !== 1'b1) begin miscompares++; $display("FAIL hold_valid_%0d got %b want 1", k, resp_valid); end
            vectors++; if (resp_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL hold_rdata_%0d got %h want deadbeef", k, resp_rdata); end
            vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL hold_ready_%0d got %b want 0", k, req_ready); end
        end
        resp_ready = 1'b1;
        tick();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release_valid got %b want 0", resp_valid); end
        vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL hold_release_ready got %b want 1", req_ready); end
    endtask

    task automatic test_reset_abort();
        logic [N-1:0] rd;
        logic er;
        int lat;
        do_txn(1'b1, 32'h20, 32'h00000000, rd, er, lat);
        tick();
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        tick();
        rst = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid got %b want 0", resp_valid); end
        vectors++; if (resp_rdata !== 32'h0) begin miscompares++; $display("FAIL abort_rdata got %h want 0", resp_rdata); end
        vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL abort_err got %b want 0", resp_err); end
        vectors++; if (req_ready !== 1'b0) begin miscompares++; $display("FAIL abort_ready got %b want 0", req_ready); end
        tick();
        tick();
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_resp got %b want 0", resp_valid); end
        rst = 1'b1;
        tick();
        do_txn(1'b0, 32'h20, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'h00000000) begin miscompares++; $display("FAIL abort_mem got %h want 00000000", rd); end
        tick();
        // Reset while a store response is pending: the write is already committed.
        resp_ready = 1'b0;
        do_txn(1'b1, 32'h24, 32'hCAFEF00D, rd, er, lat);
        rst = 1'b0;
        #1;
        vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL resp_drop_valid got %b want 0", resp_valid); end
        tick();
        rst = 1'b1;
        resp_ready = 1'b1;
        tick();
        do_txn(1'b0, 32'h24, 32'h0, rd, er, lat);
        vectors++; if (rd !== 32'hCAFEF00D) begin miscompares++; $display("FAIL resp_drop_mem got %h want cafef00d", rd); end
        tick();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int guard;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0;
        resp_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (req_ready) acc.push_back(c);
            tick();
        end
        req_valid = 1'b0;
        vectors++; if (acc.size() !== 4) begin miscompares++; $display("FAIL b2b_count got %0d want 4", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            vectors++; if (acc[i] - acc[i-1] !== 4) begin miscompares++; $display("FAIL b2b_spacing_%0d got %0d want 4", i, acc[i] - acc[i-1]); end
        end
        guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
